// File: rtl/rvvi_trace_serializer_pkg.sv
// Shared types for the RVVI trace consumer: the buffered event record and
// the writeback-flag decode helper.
package rvvi_trace_pkg;

  localparam int RVVI_TRACE_VERSION_MAJOR = 1;
  localparam int RVVI_TRACE_VERSION_MINOR = 0;
  localparam int NUM_REGS = 32;
  localparam int EV_ILEN  = 32;
  localparam int EV_XLEN  = 32;
  localparam int RD_W     = $clog2(NUM_REGS);

  typedef struct packed {
    logic [63:0]         order;
    logic [EV_XLEN-1:0]  pc;
    logic [EV_ILEN-1:0]  insn;
    logic                trap;
    logic                debug;
    logic [RD_W-1:0]     rd;
    logic [EV_XLEN-1:0]  rd_wdata;
    logic                rd_we;
    logic                rd_multi;
  } rvvi_event_t;

  typedef struct packed {
    logic            found;
    logic [RD_W-1:0] idx;
    logic            multi;
  } first_set_t;

  // x0 can never be a real destination, so bit 0 is masked before the search.
  function automatic first_set_t first_set_1_31(input logic [NUM_REGS-1:0] wb);
    logic [NUM_REGS-1:0] m;
    first_set_t          r;
    m = wb & ~NUM_REGS'(1);
    r = '0;
    for (int i = NUM_REGS - 1; i >= 1; i--)
      if (m[i]) r.idx = RD_W'(i);
    r.found = |m;
    r.multi = (m & (m - NUM_REGS'(1))) != '0;
    return r;
  endfunction

endpackage

// File: rtl/rvvi_trace_serializer_if.sv
// Output event stream from the trace serializer to the checker/scoreboard.
interface rvvi_trace_serializer_if;

  logic                       out_valid;
  logic                       out_ready;
  rvvi_trace_pkg::rvvi_event_t out_event;

  modport master (output out_valid, output out_event, input out_ready);
  modport slave  (input out_valid, input out_event, output out_ready);

endinterface

// File: rtl/rvvi_trace_fifo.sv
// Multi-write / single-read FIFO. Enabled write ports are packed into
// consecutive entries in port order; the caller guarantees room.
module rvvi_trace_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  parameter int NWR   = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NWR-1:0]             wr_en,
  input  logic [NWR-1:0][W-1:0]      wr_data,
  input  logic                       rd_en,
  output logic [W-1:0]               rd_data,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]            mem [DEPTH];
  logic [AW-1:0]           wr_ptr, rd_ptr;
  logic [NWR-1:0][AW-1:0]  slot;
  logic [CW-1:0]           n_wr;
  logic                    pop;

  always_comb begin
    n_wr = '0;
    slot = '0;
    for (int i = 0; i < NWR; i++) begin
      slot[i] = wr_ptr + n_wr[AW-1:0];
      n_wr    = n_wr + CW'(wr_en[i]);
    end
  end

  assign pop     = rd_en && (count != '0);
  // Empty FIFO presents zeros rather than stale storage.
  assign rd_data = (count != '0) ? mem[rd_ptr] : '0;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NWR; i++)
      if (wr_en[i]) mem[slot[i]] <= wr_data[i];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + n_wr[AW-1:0];
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count  <= count + n_wr - CW'(pop);
    end
  end

endmodule

// File: rtl/rvvi_trace_serializer.sv
// RVVI trace consumer for one hart: builds per-slot records, checks order
// continuity, buffers all-or-nothing per cycle and streams events out.
module rvvi_trace_serializer
  import rvvi_trace_pkg::*;
#(
  parameter int ILEN   = EV_ILEN,
  parameter int XLEN   = EV_XLEN,
  parameter int RETIRE = 2,
  parameter int DEPTH  = 16
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [RETIRE-1:0]                      in_valid,
  input  logic [RETIRE-1:0][63:0]                in_order,
  input  logic [RETIRE-1:0][ILEN-1:0]            in_insn,
  input  logic [RETIRE-1:0][XLEN-1:0]            in_pc,
  input  logic [RETIRE-1:0]                      in_trap,
  input  logic [RETIRE-1:0]                      in_debug_mode,
  input  logic [RETIRE-1:0][NUM_REGS-1:0]        in_x_wb,
  input  logic [RETIRE-1:0][NUM_REGS-1:0][XLEN-1:0] in_x_wdata,
  rvvi_trace_serializer_if.master                stream,
  output logic                                   order_err,
  output logic [63:0]                            err_expected,
  output logic [63:0]                            err_observed,
  output logic                                   overflow,
  output logic [15:0]                            drop_cnt,
  input  logic                                   clr_err
);

  localparam int CW = $clog2(DEPTH) + 1;

  rvvi_event_t [RETIRE-1:0] rec;
  first_set_t               fs;

  always_comb begin
    rec = '0;
    fs  = '0;
    for (int i = 0; i < RETIRE; i++) begin
      fs              = first_set_1_31(in_x_wb[i]);
      rec[i].order    = in_order[i];
      rec[i].pc       = EV_XLEN'(in_pc[i]);
      rec[i].insn     = EV_ILEN'(in_insn[i]);
      rec[i].trap     = in_trap[i];
      rec[i].debug    = in_debug_mode[i];
      rec[i].rd_we    = fs.found;
      rec[i].rd_multi = fs.multi;
      if (fs.found) begin
        rec[i].rd       = fs.idx;
        rec[i].rd_wdata = EV_XLEN'(in_x_wdata[i][fs.idx]);
      end
    end
  end

  // Order checker: slots walk in index order, each valid slot re-seeds exp.
  logic [63:0] exp_r, exp_c;
  logic        synced_r, synced_c;
  logic        mis;
  logic [63:0] mis_exp, mis_obs;

  always_comb begin
    exp_c    = exp_r;
    synced_c = synced_r;
    mis      = 1'b0;
    mis_exp  = '0;
    mis_obs  = '0;
    for (int i = 0; i < RETIRE; i++) begin
      if (in_valid[i]) begin
        if (synced_c && (in_order[i] != exp_c) && !mis) begin
          mis     = 1'b1;
          mis_exp = exp_c;
          mis_obs = in_order[i];
        end
        exp_c    = in_order[i] + 64'd1;
        synced_c = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      exp_r        <= '0;
      synced_r     <= 1'b0;
      order_err    <= 1'b0;
      err_expected <= '0;
      err_observed <= '0;
    end else begin
      exp_r    <= exp_c;
      synced_r <= synced_c;
      if (mis) order_err <= 1'b1;
      else if (clr_err) order_err <= 1'b0;
      // A clear in the same cycle as a new error re-arms capture.
      if (mis && (!order_err || clr_err)) begin
        err_expected <= mis_exp;
        err_observed <= mis_obs;
      end else if (clr_err) begin
        err_expected <= '0;
        err_observed <= '0;
      end
    end
  end

  // Capture: free space is judged before this cycle's pop.
  logic [CW-1:0]      n, free, count;
  logic               accept, drop, pop;
  logic [RETIRE-1:0]  wr_en;
  logic [16:0]        drop_sum;
  logic [$bits(rvvi_event_t)-1:0] head;

  always_comb begin
    n = '0;
    for (int i = 0; i < RETIRE; i++) n = n + CW'(in_valid[i]);
  end

  assign free     = CW'(DEPTH) - count;
  assign accept   = (n <= free);
  assign wr_en    = accept ? in_valid : '0;
  assign drop     = (n != '0) && !accept;
  assign drop_sum = {1'b0, (clr_err ? 16'h0 : drop_cnt)} + 17'(n);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end else if (clr_err) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end
  end

  assign pop              = stream.out_valid & stream.out_ready;
  assign stream.out_valid = (count != '0);
  assign stream.out_event = head;

  rvvi_trace_fifo #(
    .W     ($bits(rvvi_event_t)),
    .DEPTH (DEPTH),
    .NWR   (RETIRE)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_data (rec),
    .rd_en   (pop),
    .rd_data (head),
    .count   (count)
  );

endmodule

// File: tb/tb_rvvi_trace_serializer.sv
// Randomized + directed bench for rvvi_trace_serializer against a queue-based
// reference model of the trace rules.
module tb_rvvi_trace_serializer;
  import rvvi_trace_pkg::*;

  localparam int RETIRE = 2;
  localparam int DEPTH  = 16;

  logic                          clk = 1'b0;
  logic                          rst_n = 1'b0;
  logic [RETIRE-1:0]             in_valid;
  logic [RETIRE-1:0][63:0]       in_order;
  logic [RETIRE-1:0][31:0]       in_insn;
  logic [RETIRE-1:0][31:0]       in_pc;
  logic [RETIRE-1:0]             in_trap;
  logic [RETIRE-1:0]             in_debug_mode;
  logic [RETIRE-1:0][31:0]       in_x_wb;
  logic [RETIRE-1:0][31:0][31:0] in_x_wdata;
  logic                          clr_err;
  logic                          order_err, overflow;
  logic [63:0]                   err_expected, err_observed;
  logic [15:0]                   drop_cnt;

  rvvi_trace_serializer_if sif ();

  rvvi_trace_serializer #(.ILEN(32), .XLEN(32), .RETIRE(RETIRE), .DEPTH(DEPTH)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_order      (in_order),
    .in_insn       (in_insn),
    .in_pc         (in_pc),
    .in_trap       (in_trap),
    .in_debug_mode (in_debug_mode),
    .in_x_wb       (in_x_wb),
    .in_x_wdata    (in_x_wdata),
    .stream        (sif),
    .order_err     (order_err),
    .err_expected  (err_expected),
    .err_observed  (err_observed),
    .overflow      (overflow),
    .drop_cnt      (drop_cnt),
    .clr_err       (clr_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [191:0] got, input logic [191:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference model state: the buffer is just a queue of expected events.
  rvvi_event_t mq[$];
  logic [63:0] m_exp;
  bit          m_synced, m_order_err, m_overflow;
  logic [63:0] m_err_exp, m_err_obs;
  int          m_drop;

  task automatic model_reset();
    mq.delete();
    m_exp = 0; m_synced = 0; m_order_err = 0; m_overflow = 0;
    m_err_exp = 0; m_err_obs = 0; m_drop = 0;
  endtask

  function automatic rvvi_event_t build_rec(int s);
    rvvi_event_t r;
    int          hits;
    r = '0;
    r.order = in_order[s];
    r.pc    = in_pc[s];
    r.insn  = in_insn[s];
    r.trap  = in_trap[s];
    r.debug = in_debug_mode[s];
    hits = 0;
    for (int k = 1; k < 32; k++) begin
      if (in_x_wb[s][k]) begin
        if (hits == 0) begin
          r.rd       = 5'(k);
          r.rd_wdata = in_x_wdata[s][k];
          r.rd_we    = 1'b1;
        end
        hits++;
      end
    end
    r.rd_multi = (hits > 1);
    return r;
  endfunction

  task automatic model_update();
    int          n, free;
    bit          pop;
    rvvi_event_t recs[$];
    if (clr_err) begin
      m_order_err = 0; m_err_exp = 0; m_err_obs = 0; m_overflow = 0; m_drop = 0;
    end
    n = 0;
    for (int s = 0; s < RETIRE; s++) begin
      if (in_valid[s]) begin
        n++;
        if (m_synced && in_order[s] != m_exp && !m_order_err) begin
          m_order_err = 1; m_err_exp = m_exp; m_err_obs = in_order[s];
        end
        m_exp = in_order[s] + 1;
        m_synced = 1;
        recs.push_back(build_rec(s));
      end
    end
    free = DEPTH - mq.size();
    pop  = (mq.size() != 0) && sif.out_ready;
    if (n > free) begin
      m_overflow = 1;
      m_drop = (m_drop + n > 65535) ? 65535 : m_drop + n;
    end
    if (pop) void'(mq.pop_front());
    if (n <= free) foreach (recs[k]) mq.push_back(recs[k]);
  endtask

  task automatic check_outputs();
    check("out_valid", sif.out_valid, mq.size() != 0);
    if (mq.size() != 0) check("out_event", sif.out_event, mq[0]);
    check("order_err", order_err, m_order_err);
    check("err_expected", err_expected, m_err_exp);
    check("err_observed", err_observed, m_err_obs);
    check("overflow", overflow, m_overflow);
    check("drop_cnt", drop_cnt, m_drop);
  endtask

  // Inputs are set at the falling edge; the model advances with the DUT.
  task automatic step();
    model_update();
    @(posedge clk);
    @(negedge clk);
    check_outputs();
  endtask

  task automatic rand_payload();
    for (int s = 0; s < RETIRE; s++) begin
      in_insn[s] = $urandom; in_pc[s] = $urandom;
      in_trap[s] = 1'($urandom); in_debug_mode[s] = 1'($urandom);
      case ($urandom_range(0, 4))
        0: in_x_wb[s] = 32'h0;
        1: in_x_wb[s] = 32'h1;
        2: in_x_wb[s] = 32'h1 << $urandom_range(1, 31);
        3: in_x_wb[s] = (32'h1 << $urandom_range(0, 31)) | (32'h1 << $urandom_range(0, 31));
        default: in_x_wb[s] = $urandom;
      endcase
      for (int r = 0; r < 32; r++) in_x_wdata[s][r] = $urandom;
    end
  endtask

  task automatic send1(input logic [63:0] ord);
    rand_payload();
    in_valid = 2'b01; in_order[0] = ord;
    step();
    in_valid = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out_valid", sif.out_valid, 0);
    check("rst_out_event", sif.out_event, 0);
    check("rst_order_err", order_err, 0);
    check("rst_overflow", overflow, 0);
    check("rst_drop_cnt", drop_cnt, 0);
    check("rst_err_exp", err_expected, 0);
    rst_n = 1'b1;
  endtask

  task automatic drain(output int cnt);
    in_valid = '0; sif.out_ready = 1'b1;
    cnt = 0;
    while (sif.out_valid && cnt < 40) begin
      step();
      cnt++;
    end
    check("drain_bound", sif.out_valid, 0);
  endtask

  logic [63:0] next_ord;
  int          cnt, bias;

  initial begin
    in_valid = '0; in_order = '0; clr_err = 1'b0; sif.out_ready = 1'b0;
    rand_payload();
    model_reset();
    @(negedge clk);
    do_reset();

    // Mixed slot groups, buffered then read back in order.
    in_valid = 2'b01; in_order[0] = 5; step();
    in_valid = 2'b11; in_order[0] = 6; in_order[1] = 7; step();
    in_valid = 2'b10; in_order[1] = 8; step();
    in_valid = '0; sif.out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t1_order", sif.out_event.order, 64'(5 + k));
      step();
    end
    check("t1_empty", sif.out_valid, 0);
    check("t1_no_err", order_err, 0);

    // Gap detection, first-error hold, clear, resync.
    do_reset();
    send1(10);
    send1(12);
    check("t2_err", order_err, 1);
    check("t2_exp", err_expected, 11);
    check("t2_obs", err_observed, 12);
    send1(13);
    check("t2_hold_exp", err_expected, 11);
    check("t2_hold_obs", err_observed, 12);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    check("t2_clr", order_err, 0);
    send1(14);
    check("t2_clean", order_err, 0);
    drain(cnt);

    // Writeback decode.
    rand_payload();
    sif.out_ready = 1'b0;
    in_valid = 2'b01; in_order[0] = 15;
    in_x_wb[0] = 32'h0000_0009; in_x_wdata[0][3] = 32'hDEAD_BEEF;
    step();
    check("t4_rd", sif.out_event.rd, 3);
    check("t4_we", sif.out_event.rd_we, 1);
    check("t4_multi", sif.out_event.rd_multi, 0);
    check("t4_wdata", sif.out_event.rd_wdata, 32'hDEAD_BEEF);
    sif.out_ready = 1'b1;
    in_order[0] = 16; in_x_wb[0] = 32'h1;
    step();
    check("t4_x0_we", sif.out_event.rd_we, 0);
    check("t4_x0_rd", sif.out_event.rd, 0);
    drain(cnt);

    // Overflow with a stalled consumer.
    sif.out_ready = 1'b0;
    next_ord = 17;
    for (int c = 0; c < 9; c++) begin
      rand_payload();
      in_valid = 2'b11; in_order[0] = next_ord; in_order[1] = next_ord + 1;
      next_ord += 2;
      step();
    end
    check("t3_overflow", overflow, 1);
    check("t3_drop", drop_cnt, 2);
    check("t3_head", sif.out_event.order, 17);
    check("t3_no_err", order_err, 0);

    // Near-full push/pop interplay.
    in_valid = '0; sif.out_ready = 1'b1; step();
    send1(35);
    check("t5_accept", drop_cnt, 2);
    sif.out_ready = 1'b0; send1(36);
    sif.out_ready = 1'b1; send1(37);
    check("t5_drop", drop_cnt, 3);
    drain(cnt);
    check("t5_count", cnt, 15);

    // Asynchronous reset while holding events.
    sif.out_ready = 1'b0;
    for (int k = 0; k < 5; k++) send1(64'(38 + k));
    check("t6_pre", sif.out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("t6_async", sif.out_valid, 0);
    model_reset();
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    sif.out_ready = 1'b1;
    send1(1000);
    check("t6_baseline", order_err, 0);
    send1(1001);
    check("t6_follow", order_err, 0);

    // Random traffic: gaps, reuse, stalls, clears, one mid-run reset.
    next_ord = 1002; bias = 80;
    for (int c = 0; c < 3000; c++) begin
      if (c % 200 == 0) bias = $urandom_range(5, 100);
      if (c == 1500) do_reset();
      rand_payload();
      in_valid = RETIRE'($urandom);
      for (int s = 0; s < RETIRE; s++) begin
        int r;
        r = $urandom_range(0, 99);
        if (r < 3) next_ord += $urandom_range(1, 5);
        else if (r < 5) next_ord -= 1;
        in_order[s] = in_valid[s] ? next_ord : {$urandom, $urandom};
        if (in_valid[s]) next_ord++;
      end
      sif.out_ready = ($urandom_range(0, 99) < bias);
      clr_err = ($urandom_range(0, 99) < 2);
      step();
    end
    clr_err = 1'b0;
    drain(cnt);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
